// File: rtl/uart_led_pkg.sv
// Shared opcode, mode and FSM encodings for the UART LED controller.
package uart_led_pkg;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_ONEHOT = 3'd1;
   localparam logic [2:0] OP_ALL    = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_BLINK  = 3'd4;
   localparam logic [2:0] OP_CHASE  = 3'd5;
   localparam logic [2:0] OP_STOP   = 3'd6;
   localparam logic [2:0] OP_RSVD   = 3'd7;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_CHASE  = 2'd2
   } mode_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_ARG = 1'b1
   } state_e;

endpackage

// File: rtl/uart_led_tick.sv
// Free-running prescaler producing a one-cycle animation tick every TICK_DIV clocks.
module uart_led_tick #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= wrap;
         cnt  <= wrap ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_led_ctrl.sv
// UART byte-command LED controller: static, blink and chase modes plus multi-byte LOAD.
// Define UART_LED_TIMEOUT_EN to abort a stalled LOAD after TIMEOUT_TICKS ticks.
module uart_led_ctrl #(
   parameter int unsigned LED_W         = 4,
   parameter int unsigned TICK_DIV      = 50000,
   parameter int unsigned TIMEOUT_TICKS = 1000
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic             cmd_ack,
   output logic             cmd_err
);
   import uart_led_pkg::*;

   localparam int unsigned NB   = (LED_W + 7) / 8;
   localparam int unsigned SH_W = NB * 8;
   localparam int unsigned BC_W = 2;
   localparam int unsigned RC_W = 4;

   if (LED_W < 1 || LED_W > 32 || TICK_DIV < 1 || TIMEOUT_TICKS < 1) begin : g_param_check
      $error("uart_led_ctrl: parameter out of range");
   end

   logic             tick;
   state_e           state;
   mode_e            mode_q, mode_d;
   logic [LED_W-1:0] pattern, pattern_d, rot_l, rot_r, led_d, load_pat;
   logic             phase, phase_d, dir_right, dir_d;
   logic [RC_W-1:0]  rate_m1, rate_d, rate_cnt, rcnt_d;
   logic [BC_W-1:0]  byte_cnt;
   logic [SH_W-1:0]  shreg, shift_n;
   logic [2:0]       opcode;
   logic [4:0]       arg;
   logic             step, last_byte, timeout, ack_d, err_d;

   uart_led_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .tick      (tick)
   );

   assign opcode    = rx_data[7:5];
   assign arg       = rx_data[4:0];
   assign shift_n   = SH_W'({rx_data, shreg} >> 8);
   assign load_pat  = shift_n[LED_W-1:0];
   assign last_byte = (byte_cnt == BC_W'(NB - 1));
   assign step      = tick && (rate_cnt == rate_m1);
   assign mode      = mode_q;

   if (LED_W == 1) begin : g_rot_one
      assign rot_l = pattern;
      assign rot_r = pattern;
   end else begin : g_rot
      assign rot_l = {pattern[LED_W-2:0], pattern[LED_W-1]};
      assign rot_r = {pattern[0], pattern[LED_W-1:1]};
   end

`ifdef UART_LED_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
   logic [TO_W-1:0] to_cnt;

   assign timeout = (state == ST_WAIT_ARG) && !rx_valid && tick &&
                    (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

   // Ticks since the last LOAD byte; idle outside WAIT_ARG.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                            to_cnt <= '0;
      else if (state != ST_WAIT_ARG || rx_valid) to_cnt <= '0;
      else if (tick)                             to_cnt <= to_cnt + TO_W'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   // Animation step first; a decoded command then overrides it where it must.
   always_comb begin
      pattern_d = pattern;
      mode_d    = mode_q;
      phase_d   = phase;
      rate_d    = rate_m1;
      dir_d     = dir_right;
      rcnt_d    = rate_cnt;
      ack_d     = 1'b0;
      err_d     = 1'b0;

      if (tick) rcnt_d = step ? '0 : rate_cnt + RC_W'(1);
      if (step) begin
         if (mode_q == MODE_BLINK)      phase_d   = ~phase;
         else if (mode_q == MODE_CHASE) pattern_d = dir_right ? rot_r : rot_l;
      end

      if (rx_valid && state == ST_WAIT_ARG) begin
         if (last_byte) begin
            pattern_d = load_pat;
            mode_d    = MODE_STATIC;
            ack_d     = 1'b1;
         end
      end else if (rx_valid) begin
         case (opcode)
            OP_NOP:    ack_d = 1'b1;
            OP_ONEHOT: begin
               pattern_d = (32'(arg) < LED_W) ? (LED_W'(1) << arg) : '0;
               mode_d    = MODE_STATIC;
               ack_d     = 1'b1;
            end
            OP_ALL: begin
               pattern_d = {LED_W{arg[0]}};
               mode_d    = MODE_STATIC;
               ack_d     = 1'b1;
            end
            OP_LOAD:   ;
            OP_BLINK: begin
               pattern_d = pattern;
               rate_d    = arg[3:0];
               phase_d   = 1'b1;
               rcnt_d    = '0;
               mode_d    = MODE_BLINK;
               ack_d     = 1'b1;
            end
            OP_CHASE: begin
               pattern_d = pattern;
               phase_d   = phase;
               rate_d    = arg[3:0];
               dir_d     = arg[4];
               rcnt_d    = '0;
               mode_d    = MODE_CHASE;
               ack_d     = 1'b1;
            end
            OP_STOP: begin
               pattern_d = pattern;
               phase_d   = phase;
               rcnt_d    = '0;
               mode_d    = MODE_STATIC;
               ack_d     = 1'b1;
            end
            OP_RSVD:   err_d = 1'b1;
            default:   ;
         endcase
      end else if (timeout) begin
         err_d = 1'b1;
      end

      led_d = (mode_d == MODE_BLINK && !phase_d) ? '0 : pattern_d;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         byte_cnt  <= '0;
         shreg     <= '0;
         pattern   <= '0;
         mode_q    <= MODE_STATIC;
         phase     <= 1'b1;
         rate_m1   <= '0;
         dir_right <= 1'b0;
         rate_cnt  <= '0;
         led       <= '0;
         cmd_ack   <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         pattern   <= pattern_d;
         mode_q    <= mode_d;
         phase     <= phase_d;
         rate_m1   <= rate_d;
         dir_right <= dir_d;
         rate_cnt  <= rcnt_d;
         led       <= led_d;
         cmd_ack   <= ack_d;
         cmd_err   <= err_d;
         case (state)
            ST_IDLE: begin
               if (rx_valid && opcode == OP_LOAD) begin
                  state    <= ST_WAIT_ARG;
                  byte_cnt <= '0;
               end
            end
            ST_WAIT_ARG: begin
               if (rx_valid) begin
                  shreg    <= shift_n;
                  byte_cnt <= byte_cnt + BC_W'(1);
                  if (last_byte) state <= ST_IDLE;
               end else if (timeout) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Bench for uart_led_ctrl: 4-LED and 12-LED instances, scoreboarded command vectors plus timing sequences.
module tb_uart_led_ctrl;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [7:0]  rx_data4, rx_data12;
   logic        rx_valid4, rx_valid12;
   logic [3:0]  led4;
   logic [11:0] led12;
   logic [1:0]  mode4, mode12;
   logic        ack4, ack12, err4, err12;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          sel;
      logic [7:0]  data;
      logic [11:0] led;
      logic [1:0]  mode;
      logic        ack;
      logic        err;
   } exp_t;

   typedef struct {
      logic [7:0] d;
      logic [3:0] led;
      logic [1:0] mode;
      logic       ack;
      logic       err;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[14];

   uart_led_ctrl #(.LED_W(4), .TICK_DIV(4), .TIMEOUT_TICKS(3)) u4 (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rx_data   (rx_data4),
      .rx_valid  (rx_valid4),
      .led       (led4),
      .mode      (mode4),
      .cmd_ack   (ack4),
      .cmd_err   (err4)
   );

   uart_led_ctrl #(.LED_W(12), .TICK_DIV(4), .TIMEOUT_TICKS(3)) u12 (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rx_data   (rx_data12),
      .rx_valid  (rx_valid12),
      .led       (led12),
      .mode      (mode12),
      .cmd_ack   (ack12),
      .cmd_err   (err12)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic compare_front();
      exp_t        e;
      logic [11:0] aled;
      logic [1:0]  amode;
      logic        aack, aerr;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty actual=0 expected=1");
         return;
      end
      e = sbq.pop_front();
      if (e.sel) begin
         aled = led12; amode = mode12; aack = ack12; aerr = err12;
      end else begin
         aled = {8'h00, led4}; amode = mode4; aack = ack4; aerr = err4;
      end
      chk($sformatf("led_after_%02h", e.data),  32'(aled),  32'(e.led));
      chk($sformatf("mode_after_%02h", e.data), 32'(amode), 32'(e.mode));
      chk($sformatf("ack_after_%02h", e.data),  32'(aack),  32'(e.ack));
      chk($sformatf("err_after_%02h", e.data),  32'(aerr),  32'(e.err));
   endtask

   // Called at a negedge; strobes one byte and checks the outputs one cycle later.
   task automatic send(input bit sel, input logic [7:0] d, input logic [11:0] eled,
                       input logic [1:0] emode, input logic eack, input logic eerr);
      exp_t e;
      e.sel = sel; e.data = d; e.led = eled; e.mode = emode; e.ack = eack; e.err = eerr;
      sbq.push_back(e);
      if (sel) begin
         rx_data12 = d; rx_valid12 = 1'b1;
      end else begin
         rx_data4 = d; rx_valid4 = 1'b1;
      end
      @(posedge sys_clk);
      @(negedge sys_clk);
      rx_valid4  = 1'b0;
      rx_valid12 = 1'b0;
      compare_front();
   endtask

   // kind 0 = blink, 1 = chase left, 2 = chase right; per = expected clocks between steps.
   task automatic watch(input int kind, input logic [3:0] pat, input int per, input int nsteps,
                        input logic [3:0] start, output logic [3:0] last);
      logic [3:0] cur, nxt;
      int cyc, steps, total;
      cur = start; cyc = 0; steps = 0; total = 0;
      while (steps < nsteps && total < per * (nsteps + 2)) begin
         @(negedge sys_clk);
         cyc++;
         total++;
         if (led4 !== cur) begin
            case (kind)
               0:       nxt = (cur == 4'h0) ? pat : 4'h0;
               1:       nxt = {cur[2:0], cur[3]};
               default: nxt = {cur[0], cur[3:1]};
            endcase
            chk($sformatf("anim%0d_step%0d_led", kind, steps), 32'(led4), 32'(nxt));
            if (steps == 0) chk($sformatf("anim%0d_first_gap_ok_%0d", kind, cyc),
                                32'(cyc <= per && cyc > per - 4), 32'd1);
            else            chk($sformatf("anim%0d_gap", kind), 32'(cyc), 32'(per));
            cur = nxt;
            cyc = 0;
            steps++;
         end
      end
      if (steps < nsteps) begin
         checks++;
         failures++;
         $display("FAIL anim%0d_timeout actual_steps=%0d expected_steps=%0d", kind, steps, nsteps);
      end
      last = cur;
   endtask

   initial begin
      logic [3:0] last;
      int         cyc;
      bit         got;

      tbl[0]  = '{8'h22, 4'h4, 2'd0, 1'b1, 1'b0};
      tbl[1]  = '{8'h00, 4'h4, 2'd0, 1'b1, 1'b0};
      tbl[2]  = '{8'h25, 4'h0, 2'd0, 1'b1, 1'b0};
      tbl[3]  = '{8'h23, 4'h8, 2'd0, 1'b1, 1'b0};
      tbl[4]  = '{8'h41, 4'hF, 2'd0, 1'b1, 1'b0};
      tbl[5]  = '{8'h40, 4'h0, 2'd0, 1'b1, 1'b0};
      tbl[6]  = '{8'hE0, 4'h0, 2'd0, 1'b0, 1'b1};
      tbl[7]  = '{8'h60, 4'h0, 2'd0, 1'b0, 1'b0};
      tbl[8]  = '{8'hA5, 4'h5, 2'd0, 1'b1, 1'b0};
      tbl[9]  = '{8'h21, 4'h2, 2'd0, 1'b1, 1'b0};
      tbl[10] = '{8'hFF, 4'h2, 2'd0, 1'b0, 1'b1};
      tbl[11] = '{8'h60, 4'h2, 2'd0, 1'b0, 1'b0};
      tbl[12] = '{8'hE3, 4'h3, 2'd0, 1'b1, 1'b0};
      tbl[13] = '{8'hC0, 4'h3, 2'd0, 1'b1, 1'b0};

      sys_rst_n  = 1'b0;
      rx_data4   = 8'h00;
      rx_data12  = 8'h00;
      rx_valid4  = 1'b0;
      rx_valid12 = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      chk("reset_led4",   32'(led4),   32'd0);
      chk("reset_mode4",  32'(mode4),  32'd0);
      chk("reset_ack4",   32'(ack4),   32'd0);
      chk("reset_err4",   32'(err4),   32'd0);
      chk("reset_led12",  32'(led12),  32'd0);

      // Static command vectors on the 4-LED instance.
      for (int i = 0; i < 14; i++) begin
         send(1'b0, tbl[i].d, {8'h00, tbl[i].led}, tbl[i].mode, tbl[i].ack, tbl[i].err);
         @(negedge sys_clk);
         chk($sformatf("ack_pulse_end_%0d", i), 32'(ack4), 32'd0);
         chk($sformatf("err_pulse_end_%0d", i), 32'(err4), 32'd0);
      end

      // Blink: all on, rate 1.
      send(1'b0, 8'h41, 12'h00F, 2'd0, 1'b1, 1'b0);
      send(1'b0, 8'h80, 12'h00F, 2'd1, 1'b1, 1'b0);
      watch(0, 4'hF, 4, 4, 4'hF, last);
      chk("blink_mode", 32'(mode4), 32'd1);

      // Chase left, rate 2, then stop mid-chase.
      send(1'b0, 8'h20, 12'h001, 2'd0, 1'b1, 1'b0);
      send(1'b0, 8'hA1, 12'h001, 2'd2, 1'b1, 1'b0);
      watch(1, 4'h0, 8, 4, 4'h1, last);
      repeat (3) @(negedge sys_clk);
      send(1'b0, 8'hC0, {8'h00, last}, 2'd0, 1'b1, 1'b0);
      repeat (12) @(negedge sys_clk);
      chk("stop_frozen_led", 32'(led4), 32'(last));
      chk("stop_mode", 32'(mode4), 32'd0);

      // Chase right, rate 1.
      send(1'b0, 8'hB0, {8'h00, last}, 2'd2, 1'b1, 1'b0);
      watch(2, 4'h0, 4, 3, last, last);
      send(1'b0, 8'hC0, {8'h00, last}, 2'd0, 1'b1, 1'b0);

      // Leave the 4-LED instance blinking to check reset mid-animation.
      send(1'b0, 8'h81, {8'h00, last}, 2'd1, 1'b1, 1'b0);

      // 12-LED multi-byte loads and boundaries.
      send(1'b1, 8'h60, 12'h000, 2'd0, 1'b0, 1'b0);
      send(1'b1, 8'hAB, 12'h000, 2'd0, 1'b0, 1'b0);
      send(1'b1, 8'h0F, 12'hFAB, 2'd0, 1'b1, 1'b0);
      send(1'b1, 8'hE0, 12'hFAB, 2'd0, 1'b0, 1'b1);
      send(1'b1, 8'h60, 12'hFAB, 2'd0, 1'b0, 1'b0);
      send(1'b1, 8'hFF, 12'hFAB, 2'd0, 1'b0, 1'b0);
      send(1'b1, 8'hFF, 12'hFFF, 2'd0, 1'b1, 1'b0);
      send(1'b1, 8'h22, 12'h004, 2'd0, 1'b1, 1'b0);
      send(1'b1, 8'h2B, 12'h800, 2'd0, 1'b1, 1'b0);
      send(1'b1, 8'h2C, 12'h000, 2'd0, 1'b1, 1'b0);
      send(1'b1, 8'h41, 12'hFFF, 2'd0, 1'b1, 1'b0);
      send(1'b1, 8'h60, 12'hFFF, 2'd0, 1'b0, 1'b0);
      send(1'b1, 8'h12, 12'hFFF, 2'd0, 1'b0, 1'b0);

      // Asynchronous reset mid-LOAD and mid-blink.
      sys_rst_n = 1'b0;
      #2;
      chk("midreset_led12", 32'(led12), 32'd0);
      chk("midreset_led4",  32'(led4),  32'd0);
      chk("midreset_mode4", 32'(mode4), 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      send(1'b1, 8'h21, 12'h002, 2'd0, 1'b1, 1'b0);
      repeat (10) @(negedge sys_clk);
      chk("postreset_led4",  32'(led4),  32'd0);
      chk("postreset_mode4", 32'(mode4), 32'd0);

`ifdef UART_LED_TIMEOUT_EN
      send(1'b0, 8'h22, 12'h004, 2'd0, 1'b1, 1'b0);
      send(1'b0, 8'h60, 12'h004, 2'd0, 1'b0, 1'b0);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge sys_clk);
         cyc++;
         if (err4) got = 1'b1;
      end
      chk("timeout_err_seen", 32'(got), 32'd1);
      chk($sformatf("timeout_gap_ok_%0d", cyc), 32'(cyc >= 9 && cyc <= 12), 32'd1);
      chk("timeout_led_kept", 32'(led4), 32'h4);
      send(1'b0, 8'h21, 12'h002, 2'd0, 1'b1, 1'b0);
`else
      cyc = 0;
      got = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

endmodule
